// File: rtl/vram_dma.sv
// Byte-copy DMA from the CPU address space into the 8 KB LCD VRAM.
// CPU programs SRC/DST/LEN through byte registers; the CPU is halted while the copy runs.
module vram_dma #(
  parameter int unsigned BLOCK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_cs,
  input  logic        reg_we,
  input  logic [2:0]  reg_addr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_din,
  input  logic        mem_ack,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        vram_we,
  output logic        busy,
  output logic        cpu_halt
);

  localparam int unsigned BlkW = $clog2(BLOCK);
  // Wide enough to hold 256 * BLOCK (LEN == 0).
  localparam int unsigned RemW = 9 + BlkW;

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic [15:0]       src_q, src_d;
  logic [12:0]       dst_q, dst_d;
  logic [7:0]        len_q, len_d;
  logic [15:0]       src_cnt_q, src_cnt_d;
  logic [12:0]       dst_cnt_q, dst_cnt_d;
  logic [RemW-1:0]   remain_q, remain_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, mem_rd_q, vram_we_q;
  logic              reg_wr;
  logic              start;

  // CPU-side writes are locked out for the whole transfer.
  assign reg_wr = reg_cs & reg_we & (state_q == StIdle);
  assign start  = reg_wr & (reg_addr == 3'd5) & reg_din[7];

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    src_cnt_d = src_cnt_q;
    dst_cnt_d = dst_cnt_q;
    remain_d  = remain_q;
    data_d    = data_q;

    if (reg_wr) begin
      case (reg_addr)
        3'd0:    src_d[7:0]  = reg_din;
        3'd1:    src_d[15:8] = reg_din;
        3'd2:    dst_d[7:0]  = reg_din;
        3'd3:    dst_d[12:8] = reg_din[4:0];
        3'd4:    len_d       = reg_din;
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          src_cnt_d = src_q;
          dst_cnt_d = dst_q;
          remain_d  = RemW'({(len_q == 8'd0), len_q}) << BlkW;
          state_d   = StRead;
        end
      end
      StRead: begin
        if (mem_ack) begin
          data_d  = mem_din;
          state_d = StWrite;
        end
      end
      StWrite: begin
        src_cnt_d = src_cnt_q + 16'd1;
        dst_cnt_d = dst_cnt_q + 13'd1;
        remain_d  = remain_q - RemW'(1);
        state_d   = (remain_q == RemW'(1)) ? StIdle : StRead;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      src_cnt_q <= '0;
      dst_cnt_q <= '0;
      remain_q  <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      vram_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      src_cnt_q <= src_cnt_d;
      dst_cnt_q <= dst_cnt_d;
      remain_q  <= remain_d;
      data_q    <= data_d;
      // Strobes are flopped from the next state so every output leaves a register.
      busy_q    <= (state_d != StIdle);
      mem_rd_q  <= (state_d == StRead);
      vram_we_q <= (state_d == StWrite);
    end
  end

  always_comb begin
    reg_dout = 8'h00;
    case (reg_addr)
      3'd0:    reg_dout = src_q[7:0];
      3'd1:    reg_dout = src_q[15:8];
      3'd2:    reg_dout = dst_q[7:0];
      3'd3:    reg_dout = {3'b000, dst_q[12:8]};
      3'd4:    reg_dout = len_q;
      3'd5:    reg_dout = {busy_q, 7'b0};
      default: reg_dout = 8'h00;
    endcase
  end

  assign mem_addr  = src_cnt_q;
  assign mem_rd    = mem_rd_q;
  assign vram_addr = dst_cnt_q;
  assign vram_dout = data_q;
  assign vram_we   = vram_we_q;
  assign busy      = busy_q;
  assign cpu_halt  = busy_q;

endmodule

// File: doc/vram_dma.md
# vram_dma

Byte-copy DMA engine that fills the 8 KB LCD VRAM from the CPU address space; it is the write side of the VRAM port that the scan-out logic reads. The CPU programs source, destination and length through six byte registers and sets a start bit. The engine then copies the bytes, handshaking on the system memory read port and issuing single-cycle VRAM write strobes. `cpu_halt` stays asserted for the whole transfer.

## Interface
Parameters:
- `BLOCK`, default 16: bytes per length unit; must be a power of two.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `reg_cs`  in  1  register select, qualifies `reg_we`/`reg_addr`
- `reg_we`  in  1  register write strobe (one cycle)
- `reg_addr`  in  3  register index 0..5
- `reg_din`  in  8  register write data
- `reg_dout`  out  8  register read data (combinational from `reg_addr`)
- `mem_addr`  out  16  source read address
- `mem_rd`  out  1  source read request
- `mem_din`  in  8  source read data, valid when `mem_ack`=1
- `mem_ack`  in  1  read acknowledge, may arrive 0..n cycles after request
- `vram_addr`  out  13  VRAM write address
- `vram_dout`  out  8  VRAM write data
- `vram_we`  out  1  VRAM write strobe
- `busy`  out  1  transfer in progress
- `cpu_halt`  out  1  equals `busy`

## Operation
- Registers:
  - 0: SRC[7:0]; 1: SRC[15:8].
  - 2: DST[7:0]; 3: DST[12:8] (bits 7:5 ignored, read as 0).
  - 4: LEN.
  - 5: CTRL. Writing bit7=1 starts a transfer; reads return `{busy,7'b0}`.
- Writes to any register while `busy`=1 are ignored. Register reads are always allowed.
- Byte count = LEN×BLOCK. LEN=0 means 256×BLOCK (4096 bytes at the default).
- Work registers:
  - `src_cnt` (16 bit): SRC wraps 0xFFFF→0x0000.
  - `dst_cnt` (13 bit): wraps 0x1FFF→0x0000.
  - `remain` (13 bit).
- The CPU-visible SRC/DST/LEN registers are not modified by a transfer, so a second start repeats the same copy.
- FSM:
  - IDLE: on a CTRL write with bit7=1, load the work registers and go to READ.
  - READ: `mem_rd`=1, `mem_addr`=`src_cnt`. When `mem_ack`=1, latch `mem_din` into `data_q` and go to WRITE. `mem_ack` is ignored outside READ.
  - WRITE: `vram_we`=1 for exactly one cycle, with `vram_addr`=`dst_cnt` and `vram_dout`=`data_q`. In the same cycle, `src_cnt`+1, `dst_cnt`+1 and `remain`−1. If `remain`==1, go to IDLE; otherwise go to READ.
- `busy` is 1 in READ and WRITE and 0 in IDLE.
- A start with bit7=0 is a no-op.

## Timing
- Reset values: `mem_rd`=0, `vram_we`=0, `busy`=0, `cpu_halt`=0, `mem_addr`=0, `vram_addr`=0, `vram_dout`=0. All registers clear to 0 and the FSM is in IDLE.
- Start: CTRL write sampled at edge N. At N+1, `busy`=1 and `mem_rd`=1.
- With `mem_ack` tied high, each byte takes 2 cycles (READ, WRITE). A transfer of B bytes keeps `busy` high for exactly 2B cycles.
- Each cycle of ack latency adds one cycle in READ. `mem_addr` is stable while `mem_rd`=1.
- The last `vram_we` occurs in the final busy cycle. `busy` falls on the following edge.
- A new start is accepted in the first IDLE cycle after `busy` falls.
- `reset` asserted mid-transfer aborts on that edge, with no further strobes. A byte already latched is discarded, and VRAM bytes already written stay written.
- All outputs are registered except `reg_dout`.
- `vram_we` and `mem_rd` are never high in the same cycle.

## Test plan
- Basic copy: SRC=0x1000, DST=0x0000, LEN=1, start, `mem_ack` tied 1, `mem_din`=low byte of `mem_addr` -> 16 `vram_we` pulses, addr 0x000..0x00F, data 0x00..0x0F, `busy` high for 32 cycles.
- Ack latency: as the basic copy, but `mem_ack` arrives 3 cycles after each `mem_rd` -> same data, `busy` high 16×5=80 cycles, `mem_addr` stable during each wait.
- Wrap: SRC=0xFFF8, DST=0x1FF8, LEN=1 -> source addresses 0xFFF8..0xFFFF then 0x0000..0x0007; VRAM addresses 0x1FF8..0x1FFF then 0x000..0x007.
- LEN=0 -> exactly 4096 writes; `busy` high for 8192 cycles with immediate ack.
- Busy lockout: during a transfer, write SRC=0xAAAA, LEN=5 and CTRL=0x80 -> ignored; the transfer completes unchanged and a register read of SRC returns the original value. CTRL reads 0x80 while busy and 0x00 after.
- Reset mid-transfer: assert `reset` after the 5th `vram_we` -> next cycle `busy`=0, no further `vram_we`, all registers read 0. A fresh start then copies correctly.
